mem_access_stage: RTL

Multi-cycle data-memory stage of the five-stage pipeline. It sits between the EX/MEM register and the MEM/WB register. It takes the latched memory-control bits, the address and the store data, and performs a word access on a private data array with a fixed programmable latency. It stalls the upstream pipeline until the access completes, then presents load data for the MEM/WB register to capture.

---
 rtl/mem_access_stage.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: multi-cycle data-memory stage between EX/MEM and MEM/WB.
// A request seen in IDLE is latched, then held in BUSY for LATENCY cycles.
// The word access happens on the last BUSY edge. The result is presented
// during the single DONE cycle, when the upstream stall is released.
module mem_access_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic [1:0]  dbg_state_o
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_op_wr;
    logic [31:0] r_addr_q;
    logic [31:0] r_wdata_q;
    logic [31:0] r_data;
    logic        r_misalign;

    // Data array: not reset, so its contents survive rst_i.
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_req;
    logic          w_fire;
    logic          w_misaligned;
    logic [AW-1:0] w_idx;
    logic          w_unused_addr;

    assign w_req        = MemRead_i | MemWrite_i;
    assign w_fire       = (r_state == ST_BUSY) && (r_cnt == 4'd0);
    assign w_misaligned = (r_addr_q[1:0] != 2'b00);
    // Upper address bits are dropped, so addresses wrap modulo the array size.
    assign w_idx         = r_addr_q[AW+1:2];
    assign w_unused_addr = ^r_addr_q[31:AW+2];

    // The stall covers the request cycle itself and every BUSY cycle.
    assign stall_o     = ((r_state == ST_IDLE) && w_req) || (r_state == ST_BUSY);
    assign data_o      = r_data;
    assign misalign_o  = r_misalign;
    assign dbg_state_o = r_state;

    // Control FSM, operand latches, load-data register and misalign flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_op_wr    <= 1'b0;
            r_addr_q   <= 32'd0;
            r_wdata_q  <= 32'd0;
            r_data     <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            // The flag is a one-cycle pulse that is only raised on the access edge.
            r_misalign <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr_q  <= addr_i;
                        r_wdata_q <= data_i;
                        // A store wins when both request bits are set.
                        r_op_wr   <= MemWrite_i;
                        r_cnt     <= CNT_INIT;
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_misalign <= w_misaligned;
                        if (!r_op_wr) begin
                            r_data <= w_misaligned ? 32'd0 : r_mem[w_idx];
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Array write on the access edge. Reset on the same edge discards it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_fire && r_op_wr && !w_misaligned) begin
            r_mem[w_idx] <= r_wdata_q;
        end
    end

endmodule
